// File: rtl/wb_ram_burst.sv
// rtl/wb_ram_burst.sv - Wishbone B4 registered-feedback burst RAM slave; WB_RAM_ERR_EN enables out-of-range err_o
module wb_ram_burst #(
  parameter int    DW      = 32,
  parameter int    DEPTH   = 128,
  parameter int    AW      = $clog2(DEPTH),
  parameter string MEMFILE = ""
) (
  input  logic            clk_i,
  input  logic            rst_in,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW-1:0]   dat_i,
  input  logic [2:0]      cti_i,
  input  logic [1:0]      bte_i,
  output logic            ack_o,
  output logic            err_o,
  output logic [DW-1:0]   dat_o
);

  localparam int NB = DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] dat_q, dat_d;

  logic [DW-1:0] mem [DEPTH];

  logic          req;
  logic          burst;
  logic          wr_en;
  logic [AW-1:0] nxt;
  logic          adr_ok;
  logic          nxt_ok;

  // Address of the following burst beat: linear increment or wrap within a 4/8/16-word window
  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    inc = a + 1'b1;
    case (bte)
      2'b01:   mask = AW'(32'd3);
      2'b10:   mask = AW'(32'd7);
      2'b11:   mask = AW'(32'd15);
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  assign req   = cyc_i & stb_i;
  assign burst = req & (cti_i == 3'b010);
  assign nxt   = next_adr(adr_i, bte_i);

`ifdef WB_RAM_ERR_EN
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  assign adr_ok = ({1'b0, adr_i} < DEPTH_W);
  assign nxt_ok = ({1'b0, nxt} < DEPTH_W);
`else
  assign adr_ok = 1'b1;
  assign nxt_ok = 1'b1;
`endif

  // A write commits at the edge that closes its ack cycle; reset forces IDLE so nothing commits then
  assign wr_en = (state_q == ACTIVE) & req & we_i & adr_ok;

  // Next state, registered acknowledges and read-data prefetch
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!adr_ok) begin
            state_d = ERROR;
            err_d   = 1'b1;
            dat_d   = '0;
          end else begin
            state_d = ACTIVE;
            ack_d   = 1'b1;
            if (!we_i) dat_d = mem[adr_i];
          end
        end
      end
      ACTIVE: begin
        if (burst) begin
          if (!nxt_ok) begin
            state_d = ERROR;
            err_d   = 1'b1;
            dat_d   = '0;
          end else begin
            state_d = ACTIVE;
            ack_d   = 1'b1;
            dat_d   = mem[nxt];
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Byte-lane write port of the block RAM; contents are never cleared
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) mem[adr_i][8*k +: 8] <= dat_i[8*k +: 8];
      end
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = dat_q;

endmodule

// File: tb/tb_wb_ram_burst.sv
// tb/tb_wb_ram_burst.sv - scoreboard bench for wb_ram_burst with randomized bursts
module tb_wb_ram_burst;

  localparam int DW    = 32;
  localparam int DEPTH = 100;
  localparam int AW    = 7;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          cyc_i, stb_i, we_i;
  logic [3:0]    be_i;
  logic [AW-1:0] adr_i;
  logic [DW-1:0] dat_i;
  logic [2:0]    cti_i;
  logic [1:0]    bte_i;
  logic          ack_o, err_o;
  logic [DW-1:0] dat_o;

  wb_ram_burst #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .MEMFILE("")) dut (
    .clk_i(clk_i), .rst_in(rst_n), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .be_i(be_i), .adr_i(adr_i), .dat_i(dat_i), .cti_i(cti_i), .bte_i(bte_i),
    .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [DEPTH];
  logic [31:0] wdata [16];
  logic [3:0]  wbe   [16];
  int          checks = 0;
  int          errors = 0;
  bit          sb_bypass = 1'b1;
  bit          phantom_ok = 1'b0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int beat_addr(input int start, input int i, input logic [1:0] bte);
    int w;
    int base;
    if (bte == 2'b00) return (start + i) % (1 << AW);
    w    = 2 << bte;
    base = start - (start % w);
    return base + ((start % w) + i) % w;
  endfunction

  // Monitor: every ack/err during a live strobe consumes one expected beat
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_n && !sb_bypass && (ack_o || err_o)) begin
      if (ack_o && err_o) check(1'b0, "ack_err_together", {ack_o, err_o}, 2'b00);
      if (!(cyc_i && stb_i)) begin
        if (!phantom_ok) check(1'b0, "ack_without_strobe", {ack_o, err_o}, 2'b00);
      end else if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_ack", {ack_o, err_o}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check(err_o == e.err, "err_flag", err_o, e.err);
        if (e.err) check(dat_o == 32'h0, "err_data", dat_o, 32'h0);
        else if (e.rd) check(dat_o == e.dat, "read_data", dat_o, e.dat);
      end
    end
  end

  task automatic do_burst(input int start, input int n, input bit we, input logic [1:0] bte, input int abort_after);
    int a;
    int waits;
    int exp_w;
    bit done;
    done = 1'b0;
    for (int i = 0; i < n && !done; i++) begin
      a     = beat_addr(start, i, bte);
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = we;
      adr_i = AW'(a);
      dat_i = wdata[i];
      be_i  = wbe[i];
      bte_i = bte;
      if (n == 1) cti_i = 3'b000;
      else if (i == n - 1) cti_i = 3'b111;
      else cti_i = 3'b010;
      if (a >= DEPTH) begin
        exp_q.push_back('{1'b1, 1'b0, 32'h0});
      end else begin
        exp_q.push_back('{1'b0, !we, model[a]});
        if (we) begin
          for (int k = 0; k < 4; k++)
            if (wbe[i][k]) model[a][8*k +: 8] = wdata[i][8*k +: 8];
        end
      end
      waits = 0;
      do begin
        @(negedge clk_i);
        waits++;
      end while (!(ack_o || err_o) && waits < 20);
      exp_w = (i == 0) ? 2 : 1;
      check(waits == exp_w, "beat_latency", waits, exp_w);
      if (err_o || waits >= 20) done = 1'b1;
      @(posedge clk_i);
      #1;
      if (abort_after == i + 1) done = 1'b1;
    end
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    cti_i = 3'b000;
  endtask

  task automatic classic_read(input int a);
    wbe[0] = 4'hf;
    do_burst(a, 1, 1'b0, 2'b00, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int s;
    logic [1:0] bt;
    bit w;
    rst_n = 1'b0;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    adr_i = '0; dat_i = '0; cti_i = 3'b000; bte_i = 2'b00;
    repeat (3) @(posedge clk_i);
    #1;
    check(ack_o == 1'b0, "reset_ack", ack_o, 1'b0);
    check(err_o == 1'b0, "reset_err", err_o, 1'b0);
    check(dat_o == 32'h0, "reset_dat", dat_o, 32'h0);
    rst_n = 1'b1;
    sb_bypass = 1'b0;
    @(posedge clk_i);
    #1;

    // Single write then read back
    wdata[0] = 32'hDEADBEEF; wbe[0] = 4'hf;
    do_burst(5, 1, 1'b1, 2'b00, 0);
    classic_read(5);

    // Fill every word with known data via linear write bursts
    for (int b = 0; b < DEPTH / 4; b++) begin
      for (int i = 0; i < 4; i++) begin
        wdata[i] = $urandom;
        wbe[i]   = 4'hf;
      end
      do_burst(b * 4, 4, 1'b1, 2'b00, 0);
    end

    // Byte enables
    wdata[0] = 32'h11223344; wbe[0] = 4'hf;
    do_burst(3, 1, 1'b1, 2'b00, 0);
    wdata[0] = 32'hAABBCCDD; wbe[0] = 4'b0101;
    do_burst(3, 1, 1'b1, 2'b00, 0);
    classic_read(3);

    // be = 0 write leaves memory untouched
    wdata[0] = 32'h0BADF00D; wbe[0] = 4'h0;
    do_burst(7, 1, 1'b1, 2'b00, 0);
    classic_read(7);

    // Linear 4-beat read from 6
    do_burst(6, 4, 1'b0, 2'b00, 0);

    // Wrap4 write from 0x0E, then read back 0x0C..0x10
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'(i + 1);
      wbe[i]   = 4'hf;
    end
    do_burst(14, 4, 1'b1, 2'b01, 0);
    for (int a = 12; a <= 16; a++) classic_read(a);

    // Mid-burst abort after beat 2 of an 8-beat read
    phantom_ok = 1'b1;
    do_burst(20, 8, 1'b0, 2'b00, 2);
    @(negedge clk_i);
    @(negedge clk_i);
    check(ack_o == 1'b0, "ack_low_after_abort", ack_o, 1'b0);
    phantom_ok = 1'b0;
    @(posedge clk_i);
    #1;
    classic_read(40);

    // Randomized bursts of every type
    for (int t = 0; t < 40; t++) begin
      bt = 2'($urandom_range(0, 3));
      n  = $urandom_range(1, 8);
      w  = 1'($urandom_range(0, 1));
      if (bt == 2'b00) s = $urandom_range(0, DEPTH - n);
      else s = $urandom_range(0, 95);
      for (int i = 0; i < n; i++) begin
        wdata[i] = $urandom;
        wbe[i]   = 4'($urandom);
      end
      do_burst(s, n, w, bt, 0);
    end

`ifdef WB_RAM_ERR_EN
    // Out-of-range write, then a linear burst running past the end
    wdata[0] = 32'hCAFEF00D; wbe[0] = 4'hf;
    do_burst(100, 1, 1'b1, 2'b00, 0);
    classic_read(36);
    classic_read(99);
    do_burst(98, 4, 1'b0, 2'b00, 0);
    classic_read(98);
`endif

    // Reset asserted in the middle of a read burst
    sb_bypass = 1'b1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = AW'(10);
    cti_i = 3'b010; bte_i = 2'b00; be_i = 4'hf;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    adr_i = AW'(11);
    @(negedge clk_i);
    check(ack_o == 1'b1, "ack_before_reset", ack_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check(ack_o == 1'b0, "reset_drops_ack", ack_o, 1'b0);
    check(dat_o == 32'h0, "reset_clears_dat", dat_o, 32'h0);
    cyc_i = 1'b0; stb_i = 1'b0; cti_i = 3'b000;
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    sb_bypass = 1'b0;
    classic_read(11);

    repeat (3) @(posedge clk_i);
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
